// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the CPU datapath.
// master = sequencer, slave = datapath.
interface multicycle_control_fsm_if #(
    parameter int CNT_WIDTH = 16
);
    logic [3:0]           OPCODE;
    logic                 MemReady;
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic                 PCSource;
    logic                 IorD;
    logic                 IRWrite;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemToReg;
    logic                 RegDst;
    logic                 RegWrite;
    logic                 AluSrcA;
    logic [1:0]           AluSrcB;
    logic [1:0]           AluOP;
    logic [3:0]           State;
    logic                 Halted;
    logic [CNT_WIDTH-1:0] InstrRetired;

    modport master (
        input  OPCODE, MemReady,
        output PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOP, State,
               Halted, InstrRetired
    );

    modport slave (
        output OPCODE, MemReady,
        input  PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOP, State,
               Halted, InstrRetired
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Registered sequencer for the multi-cycle 24-bit CPU: steps each instruction
// through fetch/decode/execute/memory/write-back and counts retired instructions.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read instruction at PC, load IR and PC+1 when memory ready
// DECODE    | compute branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | compute load/store address (A + imm)
// MEM_READ  | read data memory, wait for ready
// MEM_WB    | write MDR into rt
// MEM_WRITE | write data memory, wait for ready
// R_EXEC    | ALU op A (funct) B
// R_WB      | write ALUOut into rd
// BEQ_EXEC  | compare A-B, conditional PC load from ALUOut
// ADDI_EXEC | A + imm
// ADDI_WB   | write ALUOut into rt
// HALT      | illegal opcode trapped, left only by reset
module multicycle_control_fsm #(
    parameter logic [3:0] OP_R      = 4'b0110,
    parameter logic [3:0] OP_LS     = 4'b0010,
    parameter logic [3:0] OP_SS     = 4'b0011,
    parameter logic [3:0] OP_BEQ    = 4'b0100,
    parameter logic [3:0] OP_ADDI   = 4'b0001,
    parameter int         CNT_WIDTH = 16
) (
    input logic                     Clock,
    input logic                     Reset,
    multicycle_control_fsm_if.master bus
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BEQ_EXEC  = 4'd8;
    localparam logic [3:0] S_ADDI_EXEC = 4'd9;
    localparam logic [3:0] S_ADDI_WB   = 4'd10;
    localparam logic [3:0] S_HALT      = 4'd15;

    logic [3:0]           state;
    logic [3:0]           next_state;
    logic [CNT_WIDTH-1:0] retired_cnt;
    logic                 retire;
    logic                 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_FETCH;
            retired_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        next_state    = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        bus.PCSource  = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.AluSrcA   = 1'b0;
        bus.AluSrcB   = 2'b00;
        bus.AluOP     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read    = 1'b1;
                bus.AluSrcB = 2'b01;
                if (bus.MemReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.AluSrcB = 2'b10;
                if (bus.OPCODE == OP_R)                                next_state = S_R_EXEC;
                else if (bus.OPCODE == OP_LS || bus.OPCODE == OP_SS)   next_state = S_MEM_ADDR;
                else if (bus.OPCODE == OP_BEQ)                         next_state = S_BEQ_EXEC;
                else if (bus.OPCODE == OP_ADDI)                        next_state = S_ADDI_EXEC;
                else                                                   next_state = S_HALT;
            end
            S_MEM_ADDR: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'b10;
                next_state  = (bus.OPCODE == OP_LS) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                bus.IorD = 1'b1;
                if (bus.MemReady) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                bus.MemToReg = 1'b1;
                retire       = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                bus.IorD  = 1'b1;
                if (bus.MemReady) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_R_EXEC: begin
                bus.AluSrcA = 1'b1;
                bus.AluOP   = 2'b10;
                next_state  = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                bus.RegDst = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ_EXEC: begin
                bus.AluSrcA   = 1'b1;
                bus.AluOP     = 2'b01;
                pc_write_cond = 1'b1;
                bus.PCSource  = 1'b1;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'b10;
                next_state  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

    // Strobes are killed combinationally so nothing fires during the reset cycle.
    assign bus.PCWrite      = pc_write      & ~Reset;
    assign bus.PCWriteCond  = pc_write_cond & ~Reset;
    assign bus.IRWrite      = ir_write      & ~Reset;
    assign bus.MemRead      = mem_read      & ~Reset;
    assign bus.MemWrite     = mem_write     & ~Reset;
    assign bus.RegWrite     = reg_write     & ~Reset;
    assign bus.State        = state;
    assign bus.Halted       = (state == S_HALT);
    assign bus.InstrRetired = retired_cnt;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle sequencer; a second instance with a
// 2-bit retire counter shares the stimulus to exercise counter wrap.
module tb_multicycle_control_fsm;
    logic       Clock;
    logic       Reset;
    logic [3:0] opcode;
    logic       mem_ready;
    int         checks   = 0;
    int         failures = 0;

    multicycle_control_fsm_if #(.CNT_WIDTH(16)) bus ();
    multicycle_control_fsm_if #(.CNT_WIDTH(2))  bus_w ();

    assign bus.OPCODE     = opcode;
    assign bus.MemReady   = mem_ready;
    assign bus_w.OPCODE   = opcode;
    assign bus_w.MemReady = mem_ready;

    multicycle_control_fsm #(.CNT_WIDTH(16)) dut   (.Clock(Clock), .Reset(Reset), .bus(bus));
    multicycle_control_fsm #(.CNT_WIDTH(2))  dut_w (.Clock(Clock), .Reset(Reset), .bus(bus_w));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; opcode = 4'b0110; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.State); end
        checks++;
        if (bus.InstrRetired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", bus.InstrRetired); end
        checks++;
        if (bus.Halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", bus.Halted); end
        checks++;
        if ({bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite});
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.MemRead, bus.IRWrite, bus.PCWrite, bus.AluSrcB} !== 5'b11101) begin
            failures++;
            $display("FAIL fetch_outputs got=%b exp=11101", {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.AluSrcB});
        end
    endtask

    task automatic test_r_type();
        int exp_s[4] = '{0, 1, 6, 7};
        opcode = 4'b0110; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.State !== 4'(exp_s[i])) begin failures++; $display("FAIL r_state step=%0d got=%0d exp=%0d", i, bus.State, exp_s[i]); end
            checks++;
            if ({bus.RegWrite, bus.RegDst} !== {2{exp_s[i] == 7}}) begin
                failures++; $display("FAIL r_regwrite_regdst step=%0d got=%b", i, {bus.RegWrite, bus.RegDst});
            end
            if (exp_s[i] == 6) begin
                checks++;
                if ({bus.AluSrcA, bus.AluSrcB, bus.AluOP} !== 5'b10010) begin
                    failures++; $display("FAIL r_exec_alu got=%b exp=10010", {bus.AluSrcA, bus.AluSrcB, bus.AluOP});
                end
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0 || bus.InstrRetired !== 16'd1) begin
            failures++; $display("FAIL r_retire state=%0d retired=%0d exp state=0 retired=1", bus.State, bus.InstrRetired);
        end
    endtask

    task automatic test_load();
        int   exp_s[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        logic rdy[8]   = '{1, 0, 0, 0, 0, 0, 1, 0};
        opcode = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (bus.State !== 4'(exp_s[i])) begin failures++; $display("FAIL ld_state step=%0d got=%0d exp=%0d", i, bus.State, exp_s[i]); end
            checks++;
            if ({bus.MemRead, bus.IorD, bus.RegWrite, bus.MemToReg} !==
                {(exp_s[i] == 0 || exp_s[i] == 3), exp_s[i] == 3, exp_s[i] == 4, exp_s[i] == 4}) begin
                failures++; $display("FAIL ld_ctrl step=%0d got=%b", i, {bus.MemRead, bus.IorD, bus.RegWrite, bus.MemToReg});
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0 || bus.InstrRetired !== 16'd2) begin
            failures++; $display("FAIL ld_retire state=%0d retired=%0d exp state=0 retired=2", bus.State, bus.InstrRetired);
        end
    endtask

    task automatic test_store();
        int   exp_s[5] = '{0, 0, 1, 2, 5};
        logic rdy[5]   = '{0, 1, 1, 1, 1};
        opcode = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (bus.State !== 4'(exp_s[i])) begin failures++; $display("FAIL st_state step=%0d got=%0d exp=%0d", i, bus.State, exp_s[i]); end
            checks++;
            if ({bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.MemRead & bus.MemWrite} !==
                {(exp_s[i] == 0 && rdy[i] == 1'b1), exp_s[i] == 5, 1'b0, 1'b0}) begin
                failures++; $display("FAIL st_ctrl step=%0d got=%b", i, {bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.MemRead & bus.MemWrite});
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0 || bus.InstrRetired !== 16'd3) begin
            failures++; $display("FAIL st_retire state=%0d retired=%0d exp state=0 retired=3", bus.State, bus.InstrRetired);
        end
    endtask

    task automatic test_beq();
        int exp_s[3] = '{0, 1, 8};
        opcode = 4'b0100; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.State !== 4'(exp_s[i])) begin failures++; $display("FAIL beq_state step=%0d got=%0d exp=%0d", i, bus.State, exp_s[i]); end
            checks++;
            if ({bus.PCWriteCond, bus.PCSource, bus.AluOP} !== ((exp_s[i] == 8) ? 4'b1101 : 4'b0000)) begin
                failures++; $display("FAIL beq_ctrl step=%0d got=%b", i, {bus.PCWriteCond, bus.PCSource, bus.AluOP});
            end
            tick();
        end
        checks++;
        if (bus.State !== 4'd0 || bus.InstrRetired !== 16'd4) begin
            failures++; $display("FAIL beq_retire state=%0d retired=%0d exp state=0 retired=4", bus.State, bus.InstrRetired);
        end
    endtask

    task automatic test_halt();
        opcode = 4'b1111; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (bus.State !== 4'd15 || bus.Halted !== 1'b1 || bus.InstrRetired !== 16'd4) begin
            failures++; $display("FAIL halt_entry state=%0d halted=%0b retired=%0d exp 15/1/4", bus.State, bus.Halted, bus.InstrRetired);
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            opcode    = 4'(i);
            #1;
            checks++;
            if (bus.State !== 4'd15 || bus.Halted !== 1'b1 ||
                {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite} !== 6'b0) begin
                failures++; $display("FAIL halt_hold cycle=%0d state=%0d halted=%0b", i, bus.State, bus.Halted);
            end
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.State !== 4'd0 || bus.Halted !== 1'b0 || bus.InstrRetired !== 16'd0) begin
            failures++; $display("FAIL halt_exit state=%0d halted=%0b retired=%0d exp 0/0/0", bus.State, bus.Halted, bus.InstrRetired);
        end
    endtask

    task automatic test_addi_wrap();
        int exp_s[4] = '{0, 1, 9, 10};
        opcode = 4'b0001; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.State !== 4'(exp_s[i])) begin failures++; $display("FAIL addi_state instr=%0d step=%0d got=%0d exp=%0d", k, i, bus.State, exp_s[i]); end
                if (exp_s[i] == 9) begin
                    checks++;
                    if ({bus.AluSrcA, bus.AluSrcB, bus.AluOP} !== 5'b11000) begin
                        failures++; $display("FAIL addi_exec got=%b exp=11000", {bus.AluSrcA, bus.AluSrcB, bus.AluOP});
                    end
                end
                if (exp_s[i] == 10) begin
                    checks++;
                    if ({bus.RegWrite, bus.RegDst, bus.MemToReg} !== 3'b100) begin
                        failures++; $display("FAIL addi_wb got=%b exp=100", {bus.RegWrite, bus.RegDst, bus.MemToReg});
                    end
                end
                tick();
            end
            checks++;
            if (bus.InstrRetired !== 16'(k + 1) || bus_w.InstrRetired !== 2'((k + 1) % 4)) begin
                failures++;
                $display("FAIL addi_count instr=%0d wide=%0d narrow=%0d exp %0d/%0d",
                         k, bus.InstrRetired, bus_w.InstrRetired, k + 1, (k + 1) % 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 4'b0010; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.State !== 4'd3 || bus.MemRead !== 1'b1) begin
            failures++; $display("FAIL mid_wait state=%0d memread=%0b exp 3/1", bus.State, bus.MemRead);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.MemRead !== 1'b0) begin failures++; $display("FAIL mid_strobe_drop memread=%0b exp=0", bus.MemRead); end
        tick();
        checks++;
        if (bus.State !== 4'd0 || bus.InstrRetired !== 16'd0) begin
            failures++; $display("FAIL mid_reset state=%0d retired=%0d exp 0/0", bus.State, bus.InstrRetired);
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_store();
        test_beq();
        test_halt();
        test_addi_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle build of the 24-bit CPU. It replaces the single-cycle combinational decoder with a registered state machine. It steps each instruction through fetch, decode, execute, memory and write-back, holding in memory states until the unified instruction/data memory signals ready. It drives all datapath mux selects, write enables and the 2-bit AluOP consumed by the ALU control block.

Parameters:
OP_R, 4'b0110, R-format opcode
OP_LS, 4'b0010, load-word opcode
OP_SS, 4'b0011, store-word opcode
OP_BEQ, 4'b0100, branch-if-equal opcode
OP_ADDI, 4'b0001, add-immediate opcode
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
OPCODE  input  4  instruction register bits [23:20], valid from DECODE onward
MemReady  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (ANDed in datapath)
PCSource  output  1  0: ALU result, 1: ALUOut register
IorD  output  1  memory address: 0 PC, 1 ALUOut
IRWrite  output  1  instruction register load
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemToReg  output  1  write-back data: 0 ALUOut, 1 MDR
RegDst  output  1  dest reg: 0 rt field, 1 rd field
RegWrite  output  1  register file write
AluSrcA  output  1  0 PC, 1 register A
AluSrcB  output  2  00 reg B, 01 constant 1, 10 sign-ext immediate
AluOP  output  2  00 add, 01 subtract, 10 funct-decoded
State  output  4  current state encoding (debug)
Halted  output  1  illegal opcode trapped
InstrRetired  output  CNT_WIDTH  instructions completed

Behaviour:
- State register updates on rising Clock. Reset=1 forces state FETCH, InstrRetired=0, Halted=0.
- While Reset=1, every strobe is forced 0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite.
- Outputs are decoded from state; IRWrite and PCWrite in FETCH are additionally gated by MemReady. Unlisted outputs are 0 in each state.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BEQ_EXEC=8, ADDI_EXEC=9, ADDI_WB=10, HALT=15.
- FETCH:
  - Drives MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOP=00, PCSource=0.
  - If MemReady: IRWrite=1, PCWrite=1, next DECODE. Else stay in FETCH.
- DECODE:
  - Drives AluSrcA=0, AluSrcB=10, AluOP=00 (branch target into ALUOut).
  - Next state by OPCODE: OP_R→R_EXEC; OP_LS or OP_SS→MEM_ADDR; OP_BEQ→BEQ_EXEC; OP_ADDI→ADDI_EXEC; any other→HALT.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOP=00. Next MEM_READ if OPCODE=OP_LS, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Stay until MemReady=1, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Stay until MemReady=1, then FETCH.
- R_EXEC: AluSrcA=1, AluSrcB=00, AluOP=10. Next R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0. Next FETCH.
- BEQ_EXEC: AluSrcA=1, AluSrcB=00, AluOP=01, PCWriteCond=1, PCSource=1. Next FETCH.
- ADDI_EXEC: AluSrcA=1, AluSrcB=10, AluOP=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0. Next FETCH.
- HALT: Halted=1, all strobes 0. Remains in HALT until Reset.
- Latency with MemReady always 1:
  - R, ADDI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - BEQ: 3 cycles.
  - Each wait cycle (MemReady=0) adds 1 cycle.
- InstrRetired:
  - Increments by 1 on the clock edge leaving MEM_WB, R_WB, ADDI_WB or BEQ_EXEC, and leaving MEM_WRITE with MemReady=1.
  - Wraps modulo 2^CNT_WIDTH with no flag.
  - Never increments on the transition to HALT.
- MemReady is ignored outside FETCH, MEM_READ and MEM_WRITE.
- MemRead and MemWrite are never asserted in the same cycle.
- Reset mid-operation, including during a memory wait, returns to FETCH on the next edge. Strobes drop in the reset cycle itself, and the counter clears.

Test Plan:
- Reset 2 cycles, release, MemReady=1, OPCODE=0110 → State 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. InstrRetired=1 after 4 cycles.
- OPCODE=0010, MemReady low for 3 cycles in MEM_READ → State 0,1,2,3,3,3,3,4,0. MemRead and IorD high in states 3. InstrRetired increments once.
- OPCODE=0011, MemReady=1 → State 0,1,2,5,0. MemWrite=1 only in state 5. RegWrite never asserted.
- OPCODE=0100 → BEQ_EXEC drives PCWriteCond=1, AluOP=01, PCSource=1. 3-cycle instruction.
- OPCODE=1111 → DECODE→HALT, Halted=1, State=15, strobes 0 for 20 cycles. Reset returns to FETCH with Halted=0.
- Reset asserted while in MEM_READ with MemReady=0 → MemRead=0 that cycle, State=0 next, InstrRetired=0. With CNT_WIDTH=2, 4 ADDI instructions → counter wraps to 0.
